serial_word_collector: RTL

//   Serial-to-parallel collector feeding the team's N-bit parameter register.

---
 rtl/serial_word_collector.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_word_collector.sv
// serial_word_collector
//   Serial-to-parallel collector. Shifts in N serial bits, then offers the
//   assembled word on word_out with a valid/ready handshake. The next word
//   keeps collecting while the current one waits. If a word completes while
//   the output buffer is still occupied and not being drained, that word is
//   dropped and the sticky overrun flag is set.
//
// Parameters
//   N          word width in bits (N >= 2)
//   MSB_FIRST  1: first serial bit ends up in word_out[N]
//              0: first serial bit ends up in word_out[1]
//
// Ports
//   clock        in   rising-edge clock for all state
//   reset        in   synchronous active-high reset, highest priority
//   clear        in   synchronous soft clear, same effect as reset
//   serial_in    in   serial data bit
//   serial_valid in   serial_in is sampled on this edge when 1
//   word_ready   in   downstream accepts word_out on this edge when 1
//   word_out     out  [N:1] assembled word, stable while word_valid=1
//   word_valid   out  word_out holds an unconsumed word
//   bit_count    out  [CW-1:0] bits collected toward the next word
//   overrun      out  sticky flag: a completed word was dropped
module serial_word_collector #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(N) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          serial_in,
  input  logic          serial_valid,
  input  logic          word_ready,
  output logic [N:1]    word_out,
  output logic          word_valid,
  output logic [CW-1:0] bit_count,
  output logic          overrun
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N:1]    shreg;
  logic [N:1]    shifted;
  logic          complete;
  logic          load_word;
  logic          set_overrun;

  // Shift register contents including the bit sampled on this edge.
  always_comb begin
    shifted = shreg;
    if (MSB_FIRST) begin
      shifted = {shreg[N-1:1], serial_in};
    end else begin
      shifted = {serial_in, shreg[N:2]};
    end
  end

  // The Nth bit of a word is being sampled on this edge.
  assign complete = serial_valid && (bit_count == CW'(N - 1));

  // Output-side FSM: decides whether a completed word is loaded or dropped.
  always_comb begin
    state_next  = state;
    load_word   = 1'b0;
    set_overrun = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          state_next = FULL;
          load_word  = 1'b1;
        end else begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (complete) begin
          // Buffer only counts as free if it is drained on this same edge.
          state_next = FULL;
          if (word_ready) begin
            load_word = 1'b1;
          end else begin
            set_overrun = 1'b1;
          end
        end else if (word_ready) begin
          state_next = EMPTY;
        end else begin
          state_next = FULL;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // All state: reset/clear discard everything, otherwise collect and hand off.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state     <= EMPTY;
      shreg     <= '0;
      bit_count <= '0;
      word_out  <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;
      if (serial_valid) begin
        shreg <= shifted;
        if (complete) begin
          bit_count <= '0;
        end else begin
          bit_count <= bit_count + CW'(1);
        end
      end else begin
        shreg     <= shreg;
        bit_count <= bit_count;
      end
      if (load_word) begin
        word_out <= shifted;
      end else begin
        word_out <= word_out;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

  assign word_valid = (state == FULL);

endmodule
